// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: raw PS/2 lines -> 11-bit toggle-style ps2_key event word
//
// Ports:
//   clk_sys   in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset
//   ps2_clk   in   1  raw PS/2 clock (async, idle high)
//   ps2_data  in   1  raw PS/2 data  (async, idle high)
//   ps2_key   out 11  {toggle, pressed, extended, scan[7:0]}
//   frame_err out  1  one-cycle pulse on a rejected or abandoned frame
//
// Optional: define PS2_TIMEOUT_EN to build the partial-frame watchdog.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  // index 1 = clock line, index 0 = data line
  logic [1:0]         s1_q, s2_q, filt_q;
  logic [1:0][FW-1:0] cnt_q;
  logic               fprev_q;
  state_t             state_q, state_d;
  logic [2:0]         bcnt_q, bcnt_d, skip_q, skip_d;
  logic [7:0]         sh_q, sh_d;
  logic               par_q, par_d, ext_q, ext_d, brk_q, brk_d, err_q, err_d;
  logic [10:0]        key_q, key_d;
  logic               fall, bit_in, ok, bad, noise;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_q    <= '1;
      s2_q    <= '1;
      filt_q  <= '1;
      fprev_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      s1_q    <= {ps2_clk, ps2_data};
      s2_q    <= s1_q;
      fprev_q <= filt_q[1];
      // run-length filter: flip only on the FILTER_LEN-th consecutive differing sample
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          cnt_q[i]  <= '0;
          filt_q[i] <= s2_q[i];
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  assign fall   = fprev_q & ~filt_q[1];
  assign bit_in = filt_q[0];
  assign noise  = sh_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
`ifdef PS2_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  always_ff @(posedge clk_sys) to_q <= reset ? '0 : to_d;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    key_d   = key_q;
    err_d   = 1'b0;
    ok      = 1'b0;
    bad     = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = bit_in ? IDLE : DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          sh_d    = {bit_in, sh_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          ok      = bit_in & (^{sh_q, par_q});
          bad     = ~ok;
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    to_d = (state_q == IDLE || fall) ? '0 : to_q + 16'd1;
    if (state_q != IDLE && to_q == 16'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      bad     = 1'b1;
      ok      = 1'b0;
      to_d    = '0;
    end
`endif
    if (bad) begin
      err_d  = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (ok) begin
      if (skip_q != 3'd0) skip_d = skip_q - 3'd1;
      else if (sh_q == 8'hE1) skip_d = 3'd7;
      else if (sh_q == 8'hE0) ext_d = 1'b1;
      else if (sh_q == 8'hF0) brk_d = 1'b1;
      else if (ext_q || brk_q || !noise) begin
        key_d = {~key_q[10], ~brk_q, ext_q, sh_q};
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end
  assign ps2_key   = key_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;
  localparam int LAT = 2 + 8 + 1;
  typedef struct {
    bit          err;
    int          lmin;
    int          lmax;
    logic [10:0] key;
  } exp_t;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_fall = 0;
  logic        tog = 1'b0;
  logic [10:0] prev = '0;
  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(48000)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key(ps2_key),
    .frame_err(frame_err)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;
  always @(negedge clk_sys) begin
    if (reset) prev = ps2_key;
    else if (frame_err || ps2_key != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: key=%h err=%b, none expected", ps2_key, frame_err);
      end else begin
        exp_t e;
        int   lat;
        e   = exp_q.pop_front();
        lat = cyc - last_fall;
        if (e.err != frame_err || (!e.err && ps2_key != e.key) || (e.err && ps2_key != prev)
            || lat < e.lmin || lat > e.lmax) begin
          failures++;
          $display("FAIL event: got key=%h err=%b lat=%0d, expected key=%h err=%b lat=%0d..%0d",
                   ps2_key, frame_err, lat, e.err ? prev : e.key, e.err, e.lmin, e.lmax);
        end
      end
      prev = ps2_key;
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask
  task automatic exp_key(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    exp_q.push_back('{1'b0, LAT, LAT, {tog, pressed, ext, code}});
  endtask
  task automatic exp_err(input int lmin, input int lmax);
    exp_q.push_back('{1'b1, lmin, lmax, 11'h0});
  endtask
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      wait_cyc(10);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bits({1'b1, ~^d ^ bad_par, d, 1'b0}, 11);
  endtask
  task automatic do_reset(input string name);
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(3);
    chk({name, "_key"}, ps2_key, 11'h0);
    chk({name, "_err"}, {10'h0, frame_err}, 11'h0);
    reset = 1'b0;
    tog   = 1'b0;
    wait_cyc(20);
  endtask
  initial begin
    logic [7:0] pause[8];
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset("reset");
    exp_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    exp_key(1'b0, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    exp_err(LAT, LAT);
    send_frame(8'h29, 1'b1);
    exp_key(1'b1, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0);
    foreach (pause[i]) send_frame(pause[i], 1'b0);
    exp_key(1'b1, 1'b0, 8'h16);
    send_frame(8'h16, 1'b0);
    send_frame(8'hAA, 1'b0);
    send_frame(8'hFA, 1'b0);
    exp_key(1'b0, 1'b0, 8'hAA);
    send_frame(8'hF0, 1'b0);
    send_frame(8'hAA, 1'b0);
    exp_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    exp_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    send_bits(11'h7FE, 10);
    exp_err(LAT, LAT);
    send_bits(11'h000, 1);
    exp_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    ps2_clk = 1'b0;
    wait_cyc(7);
    ps2_clk = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b1;
    wait_cyc(30);
    exp_key(1'b1, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b0);
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    do_reset("reset_midframe");
    exp_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
`ifdef PS2_TIMEOUT_EN
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    exp_err(48000, 48020);
    wait_cyc(50000);
    exp_key(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
`endif
    wait_cyc(100);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
